// File: rtl/manual_reset_btn.sv
// manual_reset_btn
//   Conditions the raw front-panel "reset day" push-button into a clean,
//   single-cycle manual_reset pulse for the day-reset combiner. The button
//   goes through a 2-FF synchronizer, a debounce window, a long-press
//   qualification window and a one-shot stage. Short or bouncy presses never
//   fire. A held button fires once and then waits for a debounced release.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   btn           in   raw push-button, active-high, asynchronous, may bounce
//   manual_reset  out  registered one-cycle pulse on a qualified long press
//   armed         out  registered, high while a long press is being counted
//                      or firing (present only with MANUAL_RESET_ARMED_EN)
//
// Build option
//   MANUAL_RESET_ARMED_EN  adds the armed output. manual_reset timing is the
//                          same whether or not it is defined.
//
// FSM states
//   state       | meaning
//   ST_IDLE     | button released, waiting for a press
//   ST_DEBOUNCE | press seen, counting DEBOUNCE_CYCLES stable-high cycles
//   ST_HOLD     | press accepted, counting HOLD_CYCLES more high cycles
//   ST_FIRE     | one cycle; manual_reset is high
//   ST_WAIT_REL | pulse issued, waiting for DEBOUNCE_CYCLES stable-low cycles

module manual_reset_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned HOLD_CYCLES     = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic manual_reset
`ifdef MANUAL_RESET_ARMED_EN
    ,
    output logic armed
`endif
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                                      DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_FIRE,
        ST_WAIT_REL
    } state_t;

    logic          s1_q, s1_d;
    logic          btn_sync_q, btn_sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          manual_reset_q, manual_reset_d;
`ifdef MANUAL_RESET_ARMED_EN
    logic          armed_q, armed_d;
`endif

    always_comb begin
        s1_d       = btn;
        btn_sync_d = s1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (btn_sync_q) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_sync_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!btn_sync_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT_REL;
                cnt_d   = '0;
            end
            ST_WAIT_REL: begin
                if (btn_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the cycle the FSM actually occupies that state.
        manual_reset_d = (state_d == ST_FIRE);
`ifdef MANUAL_RESET_ARMED_EN
        armed_d        = (state_d == ST_HOLD) || (state_d == ST_FIRE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q           <= 1'b0;
            btn_sync_q     <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            manual_reset_q <= 1'b0;
`ifdef MANUAL_RESET_ARMED_EN
            armed_q        <= 1'b0;
`endif
        end else begin
            s1_q           <= s1_d;
            btn_sync_q     <= btn_sync_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            manual_reset_q <= manual_reset_d;
`ifdef MANUAL_RESET_ARMED_EN
            armed_q        <= armed_d;
`endif
        end
    end

    assign manual_reset = manual_reset_q;
`ifdef MANUAL_RESET_ARMED_EN
    assign armed        = armed_q;
`endif

endmodule
